// File: rtl/sam_bus_pkg.sv
// Shared types and constants for the SAM bus memory controller.
package sam_bus_pkg;

    localparam int SAM_AW = 8;
    localparam int SAM_DW = 8;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_WAIT = 2'd1,
        LD_HOLD = 2'd2
    } ld_state_e;

endpackage

// File: rtl/sam_ram.sv
// Single-port synchronous RAM with registered read data.
// Contents are not reset; only the read register is.
module sam_ram
    import sam_bus_pkg::*;
#(
    parameter int AW = SAM_AW,
    parameter int DW = SAM_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] rdata_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sam_bus_mem.sv
// Memory-side SAM bus controller: address latch, one-cycle reads,
// same-edge writes and a front-panel program loader.
module sam_bus_mem
    import sam_bus_pkg::*;
#(
    parameter int AW = SAM_AW,
    parameter int DW = SAM_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ale,
    input  logic          en,
    input  logic          rw,
    input  logic [DW-1:0] bus_in,
    output logic [DW-1:0] bus_out,
    output logic          bus_oe,
    input  logic          prog_mode,
    input  logic          prog_we,
    input  logic [DW-1:0] prog_data,
    output logic [AW-1:0] prog_addr,
    output logic          prog_wrap,
    output logic          err
);

    logic [AW-1:0] addr_q;
    logic [AW-1:0] addr_d;
    logic          oe_q;
    logic          oe_d;
    logic          err_q;
    logic          err_d;

    ld_state_e     ld_state_q;
    logic [AW-1:0] prog_addr_q;
    logic          prog_wrap_q;

    logic          cpu_act;
    logic          rd_strobe;
    logic          wr_strobe;
    logic          wr_clash;
    logic          ld_we;

    logic          ram_we;
    logic          ram_re;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] rd_q;

    always_comb begin
        cpu_act   = !prog_mode;
        rd_strobe = cpu_act && en && (rw == RW_READ);
        wr_strobe = cpu_act && en && (rw == RW_WRITE) && !ale;
        wr_clash  = cpu_act && en && (rw == RW_WRITE) && ale;
        ld_we     = prog_mode && (ld_state_q == LD_WAIT) && prog_we;

        addr_d = addr_q;
        if (cpu_act && ale) begin
            addr_d = bus_in[AW-1:0];
        end

        oe_d  = rd_strobe;
        err_d = err_q || wr_clash;
    end

    // A read with simultaneous ALE bypasses the latch and uses the bus.
    always_comb begin
        ram_we    = ld_we || wr_strobe;
        ram_re    = rd_strobe;
        ram_wdata = bus_in;
        ram_addr  = addr_q;
        if (prog_mode) begin
            ram_addr  = prog_addr_q;
            ram_wdata = prog_data;
        end else if (ale) begin
            ram_addr = bus_in[AW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            oe_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            oe_q   <= oe_d;
            err_q  <= err_d;
        end
    end

    // Loader: one write per press; the hold state waits for release.
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_state_q  <= LD_IDLE;
            prog_addr_q <= '0;
            prog_wrap_q <= 1'b0;
        end else if (!prog_mode) begin
            ld_state_q <= LD_IDLE;
        end else begin
            unique case (ld_state_q)
                LD_IDLE: begin
                    prog_addr_q <= '0;
                    prog_wrap_q <= 1'b0;
                    ld_state_q  <= LD_WAIT;
                end
                LD_WAIT: begin
                    if (prog_we) begin
                        prog_addr_q <= prog_addr_q + 1'b1;
                        if (&prog_addr_q) begin
                            prog_wrap_q <= 1'b1;
                        end
                        ld_state_q <= LD_HOLD;
                    end
                end
                LD_HOLD: begin
                    if (!prog_we) begin
                        ld_state_q <= LD_WAIT;
                    end
                end
                default: begin
                    ld_state_q <= LD_IDLE;
                end
            endcase
        end
    end

    sam_ram #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (rd_q)
    );

    assign bus_out   = rd_q;
    assign bus_oe    = oe_q;
    assign err       = err_q;
    assign prog_addr = prog_addr_q;
    assign prog_wrap = prog_wrap_q;

endmodule

// File: tb/tb_sam_bus_mem.sv
// Scoreboard bench for sam_bus_mem: directed scenarios then random traffic
// against a behavioural memory/loader model.
module tb_sam_bus_mem;

    logic       clk;
    logic       rst;
    logic       ale;
    logic       en;
    logic       rw;
    logic [7:0] bus_drv;
    logic [7:0] bus_in;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic       prog_mode;
    logic       prog_we;
    logic [7:0] prog_data;
    logic [7:0] prog_addr;
    logic       prog_wrap;
    logic       err;

    // Resolved bus: the memory's own drive wins while it is enabled.
    assign bus_in = bus_oe ? bus_out : bus_drv;

    sam_bus_mem dut (
        .clk       (clk),
        .rst       (rst),
        .ale       (ale),
        .en        (en),
        .rw        (rw),
        .bus_in    (bus_in),
        .bus_out   (bus_out),
        .bus_oe    (bus_oe),
        .prog_mode (prog_mode),
        .prog_we   (prog_we),
        .prog_data (prog_data),
        .prog_addr (prog_addr),
        .prog_wrap (prog_wrap),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int       due;
        bit [7:0] data;
    } exp_t;

    exp_t     exp_q[$];
    int       checks = 0;
    int       errors = 0;
    int       edge_cnt = 0;
    bit       mon_on = 0;

    bit [7:0] m_mem [256];
    bit [7:0] m_addr;
    bit [7:0] m_rd;
    bit       m_oe;
    bit       m_err;
    bit [7:0] m_paddr;
    bit       m_wrap;
    bit       m_ld;
    bit       m_held;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at edge %0d",
                     name, act, exp, edge_cnt);
        end
    endtask

    function automatic void step_model();
        bit [7:0] beff;
        bit [7:0] a;
        bit       nxt_oe;
        edge_cnt++;
        if (rst) begin
            m_addr  = 0;
            m_rd    = 0;
            m_oe    = 0;
            m_err   = 0;
            m_paddr = 0;
            m_wrap  = 0;
            m_ld    = 0;
            m_held  = 0;
            return;
        end
        beff   = m_oe ? m_rd : bus_drv;
        nxt_oe = 0;
        if (!prog_mode) begin
            m_ld = 0;
            if (en && rw) begin
                a    = ale ? beff : m_addr;
                m_rd = m_mem[a];
                exp_q.push_back('{edge_cnt, m_mem[a]});
                nxt_oe = 1;
            end else if (en && !rw) begin
                if (ale) m_err = 1;
                else m_mem[m_addr] = beff;
            end
            if (ale) m_addr = beff;
        end else if (!m_ld) begin
            m_ld    = 1;
            m_held  = 0;
            m_paddr = 0;
            m_wrap  = 0;
        end else if (!m_held) begin
            if (prog_we) begin
                m_mem[m_paddr] = prog_data;
                if (m_paddr == 8'hFF) m_wrap = 1;
                m_paddr = m_paddr + 8'd1;
                m_held  = 1;
            end
        end else if (!prog_we) begin
            m_held = 0;
        end
        m_oe = nxt_oe;
    endfunction

    task automatic tick();
        @(posedge clk);
        step_model();
        #1;
    endtask

    task automatic drv(input logic a, input logic e, input logic r,
                       input logic [7:0] b);
        ale     = a;
        en      = e;
        rw      = r;
        bus_drv = b;
        tick();
    endtask

    task automatic press(input logic [7:0] d);
        prog_data = d;
        prog_we   = 1'b1;
        tick();
        prog_we   = 1'b0;
        tick();
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (exp_q.size() > 0 && exp_q[0].due == edge_cnt) begin
                chk("bus_oe_read", bus_oe, 1);
                chk("bus_out", bus_out, exp_q[0].data);
                void'(exp_q.pop_front());
            end else begin
                chk("bus_oe_idle", bus_oe, 0);
            end
            chk("prog_addr", prog_addr, m_paddr);
            chk("prog_wrap", prog_wrap, m_wrap);
            chk("err", err, m_err);
        end
    end

    initial begin
        rst = 1; ale = 0; en = 0; rw = 0; bus_drv = 0;
        prog_mode = 0; prog_we = 0; prog_data = 0;
        tick();
        tick();
        rst = 0;
        mon_on = 1;
        chk("reset_oe", bus_oe, 0);
        chk("reset_err", err, 0);
        chk("reset_paddr", prog_addr, 0);
        chk("reset_wrap", prog_wrap, 0);

        // Loader wrap: fill the whole RAM so every later read is defined.
        prog_mode = 1;
        tick();
        for (int i = 0; i < 256; i++) press(8'($urandom));
        chk("wrap_addr", prog_addr, 0);
        chk("wrap_flag", prog_wrap, 1);
        prog_mode = 0;
        tick();
        prog_mode = 1;
        tick();
        chk("wrap_clear", prog_wrap, 0);

        // Loader fill and held button.
        press(8'h61);
        press(8'h0A);
        press(8'h00);
        chk("fill_addr3", prog_addr, 3);
        prog_data = 8'h77;
        prog_we   = 1;
        repeat (5) tick();
        prog_we = 0;
        tick();
        chk("hold_once", prog_addr, 4);
        prog_mode = 0;
        tick();
        for (int i = 0; i < 5; i++) begin
            drv(1, 1, 1, 8'(i));
            drv(0, 0, 0, 8'h00);
        end

        // Read with latched address.
        drv(1, 0, 0, 8'h10);
        drv(0, 1, 0, 8'h5A);
        drv(0, 0, 0, 8'h00);
        drv(1, 0, 0, 8'h10);
        drv(0, 1, 1, 8'h00);
        drv(0, 0, 0, 8'h00);
        drv(0, 0, 0, 8'h00);

        // Bypass and indirect chaining.
        drv(1, 0, 0, 8'h20);
        drv(0, 1, 0, 8'h44);
        drv(1, 1, 1, 8'h20);
        drv(1, 0, 0, 8'hEE);
        drv(0, 1, 1, 8'h00);
        drv(0, 0, 0, 8'h00);

        // Write, read-back, then a clashing write.
        drv(1, 0, 0, 8'h30);
        drv(0, 1, 0, 8'h7E);
        drv(1, 1, 1, 8'h30);
        drv(0, 0, 0, 8'h00);
        chk("err_before_clash", err, 0);
        drv(1, 1, 0, 8'h55);
        chk("err_clash", err, 1);
        drv(1, 1, 1, 8'h30);
        drv(1, 1, 1, 8'h55);
        drv(0, 0, 0, 8'h00);

        // Reset right after a read strobe drops the drive.
        drv(1, 1, 1, 8'h30);
        rst = 1;
        drv(0, 0, 0, 8'h00);
        rst = 0;
        chk("rst_kills_oe", bus_oe, 0);
        drv(1, 0, 0, 8'h30);

        // CPU strobes are ignored in program mode.
        prog_mode = 1;
        drv(1, 1, 1, 8'h10);
        drv(1, 1, 0, 8'h99);
        drv(0, 1, 0, 8'h99);
        drv(0, 1, 1, 8'h00);
        prog_mode = 0;
        drv(0, 1, 1, 8'h00);
        drv(1, 1, 1, 8'h10);
        drv(0, 0, 0, 8'h00);

        // Mode rising right after a read strobe.
        drv(1, 1, 1, 8'h02);
        prog_mode = 1;
        drv(0, 1, 1, 8'h00);
        prog_mode = 0;
        drv(0, 0, 0, 8'h00);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) prog_mode = ~prog_mode;
            prog_we   = ($urandom_range(0, 2) == 0);
            prog_data = 8'($urandom);
            drv($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                1'($urandom), 8'($urandom));
        end
        rst = 0;
        prog_mode = 0;
        prog_we = 0;
        drv(0, 0, 0, 8'h00);
        drv(0, 0, 0, 8'h00);
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sam_bus_mem.md
# sam_bus_mem

Memory-side controller for the multiplexed 8-bit SAM bus, sitting directly downstream of the CPU controller and consuming its `ale`/`en`/`rw` strobes. It latches addresses from the shared bus and performs one-cycle-latency synchronous reads and same-edge writes into a 256×8 RAM. It also provides a front-panel program loader that fills memory from switches while the CPU is held off the bus.

## Interface
- `AW`, default 8: address width. Depth is 2^AW.
- `DW`, default 8: data and bus width.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `ale`  in  1  address latch enable from the CPU
- `en`  in  1  memory strobe from the CPU
- `rw`  in  1  1 = read, 0 = write; qualified by `en`
- `bus_in`  in  DW  resolved bus value, including this block's own drive
- `bus_out`  out  DW  read data to the bus tristate
- `bus_oe`  out  1  drive enable for `bus_out`
- `prog_mode`  in  1  loader active; CPU strobes ignored
- `prog_we`  in  1  loader write button, already debounced
- `prog_data`  in  DW  loader data switches
- `prog_addr`  out  AW  next loader write address
- `prog_wrap`  out  1  sticky flag: loader address wrapped
- `err`  out  1  sticky flag: protocol violation

## Operation
- **Address latch.** `addr_q <= bus_in` at a posedge with `ale=1` and `prog_mode=0`.
- **Read.** A posedge with `en=1`, `rw=1`, `prog_mode=0`:
  - Does `rd_q <= mem[a]`, where `a = ale ? bus_in : addr_q` (address bypass on simultaneous ALE).
  - Sets `bus_oe=1` for exactly the next cycle, with `bus_out=rd_q`.
  - Back-to-back reads keep `bus_oe` high continuously.
- **Write.** A posedge with `en=1`, `rw=0`, `ale=0`, `prog_mode=0`: `mem[addr_q] <= bus_in`. `bus_oe` stays 0.
- **Write with simultaneous `ale`.** `en=1`, `rw=0`, `ale=1`: write suppressed, address still latched, `err` set.
- **ALE while driving.** `ale=1` in a cycle where `bus_oe=1` latches the read data as the new address (indirect chaining). This is legal.
- **Loader FSM:** LD_IDLE, LD_WAIT, LD_HOLD.
  - LD_IDLE: `prog_mode` rises → `prog_addr <= 0`, go to LD_WAIT.
  - LD_WAIT: `prog_we=1` → `mem[prog_addr] <= prog_data`, `prog_addr <= prog_addr+1`, go to LD_HOLD.
    - Increment is modulo 2^AW. A 255→0 wrap sets `prog_wrap`.
  - LD_HOLD: `prog_we=0` → LD_WAIT. This gives one write per press.
  - Any state with `prog_mode=0` → LD_IDLE. `prog_addr` holds its value.
  - `prog_wrap` clears on entry to LD_WAIT from LD_IDLE.
- **Mode interaction.** While `prog_mode=1`: `bus_oe=0`, `addr_q` frozen, CPU reads and writes ignored, and `err` is not set by CPU strobes.
- **Memory port.** The RAM is single-port. Loader and CPU never access it in the same cycle, because they are mutually exclusive by `prog_mode`.

## Timing
- **Reset values:** `addr_q=0`, `rd_q=0`, `bus_out=0`, `bus_oe=0`, `prog_addr=0`, `prog_wrap=0`, `err=0`, FSM in LD_IDLE. RAM contents are preserved.
- **Read latency:** strobe sampled at edge N, data valid on the bus during cycle N+1. This matches the CPU capturing data one cycle after `en`.
- **Write latency:** memory is updated at the sampling edge. A read of the same address at the next edge returns the new data.
- **Reset mid-operation:** `rst` at the edge following a read strobe forces `bus_oe=0` in the next cycle. That read is lost.
- **Mode change mid-read:** `prog_mode` rising on the edge after a read strobe still completes that one-cycle drive. No new reads are accepted.
- **`err`:** sticky until `rst`.

## Structure
- **Package `sam_bus_pkg`:** `AW`/`DW` defaults, loader state enum (LD_IDLE, LD_WAIT, LD_HOLD), and the `RW_READ=1` / `RW_WRITE=0` constants.
- **Sub-module `sam_ram`:** single-port synchronous RAM, 2^AW × DW, with `we`, `addr`, `wdata`, and registered `rdata`. It is instantiated once; the top muxes its address and data between the CPU path and the loader.
- **Top level:** address latch, read-valid/oe register, loader FSM, and error logic.

## Test plan
1. **Loader fill.** `prog_mode=1`, then three presses with data 0x61, 0x0A, 0x00 → mem[0..2] = 0x61, 0x0A, 0x00 and `prog_addr=3`. Holding `prog_we` for 5 cycles writes only once.
2. **Loader wrap.** 256 presses → `prog_addr=0` and `prog_wrap=1`. Then `prog_mode` 0→1 → `prog_wrap=0`.
3. **Read.** mem[0x10]=0x5A. `ale` with bus 0x10, then `en=1 rw=1` → `bus_oe=1` and `bus_out=0x5A` in the following cycle only.
4. **Bypass and chaining.**
   - `ale` and `en` on the same edge with bus 0x20 → data of mem[0x20] is returned.
   - Then `ale` during the drive cycle → `addr_q` equals the driven data.
5. **Write and read-back.** `ale` with bus 0x30, `en=1 rw=0` with bus 0x7E, then read 0x30 → 0x7E. Same write attempted with `ale=1` → mem unchanged and `err=1`.
6. **Reset and mode override.** Read strobe followed by `rst` → `bus_oe=0` in the next cycle. With `prog_mode=1`, CPU read/write strobes → no drive, memory unchanged, `addr_q` unchanged.
